rom_fetch_ctrl: RTL and testbench

Instruction fetch sequencer for the program ROM. It owns the program counter and drives the ROM address. It registers each combinationally read ROM word into an instruction holding register and offers it to the decode stage over a valid/ready handshake. It supports jumps, single-step mode, end-of-program halt and out-of-range-jump fault detection.

---
 rtl/rom_fetch_ctrl_pkg.sv | 33 +++
 rtl/rom_fetch_ctrl_if.sv | 21 ++
 rtl/rom_fetch_ctrl_fetch_pc.sv | 40 ++++
 rtl/rom_fetch_ctrl.sv | 154 +++++++++++++++
 tb/tb_rom_fetch_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/rom_fetch_ctrl_pkg.sv
// Shared definitions for the program-ROM fetch sequencer: state encoding,
// default geometry and ROM word field offsets.
package rom_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam int CNTR_WIDTH_DEF = 5;
  localparam int ROM_DEPTH_DEF  = 24;

  // A ROM word is {addr field, reserved field, data field}; never narrower than one bit.
  function automatic int word_width(input int addr_w, input int undef_w, input int data_w);
    int sum;
    sum = addr_w + undef_w + data_w;
    return (sum > 0) ? sum : 1;
  endfunction

  function automatic int data_lsb();
    return 0;
  endfunction

  function automatic int undef_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int addr_lsb(input int data_w, input int undef_w);
    return data_w + undef_w;
  endfunction

endpackage

// File: rtl/rom_fetch_ctrl_if.sv
// Decode-side handshake between the fetch sequencer (master) and decode (slave).
interface rom_fetch_ctrl_if #(
  parameter int CNTR_WIDTH    = 5,
  parameter int COMBINED_DATA = 8
);
  logic [COMBINED_DATA-1:0] instr;
  logic                     instr_valid;
  logic                     instr_ready;
  logic                     jump_en;
  logic [CNTR_WIDTH-1:0]    jump_target;

  modport master (
    output instr, instr_valid,
    input  instr_ready, jump_en, jump_target
  );

  modport slave (
    input  instr, instr_valid,
    output instr_ready, jump_en, jump_target
  );
endinterface

// File: rtl/rom_fetch_ctrl_fetch_pc.sv
// Program counter with clear, increment and jump-load, plus the two range
// compares against the ROM depth used by the sequencer.
module rom_fetch_ctrl_fetch_pc #(
  parameter int CNTR_WIDTH = 5,
  parameter int ROM_DEPTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  input  logic                  load,
  input  logic [CNTR_WIDTH-1:0] target,
  output logic [CNTR_WIDTH-1:0] pc,
  output logic                  pc_in_range,
  output logic                  target_oor
);
  localparam logic [31:0] DEPTH_U = 32'(ROM_DEPTH);

  logic [CNTR_WIDTH-1:0] pc_r;

  // pc register: clear wins over a jump load, which wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= {CNTR_WIDTH{1'b0}};
    end else if (clr) begin
      pc_r <= {CNTR_WIDTH{1'b0}};
    end else if (load) begin
      pc_r <= target;
    end else if (inc) begin
      pc_r <= pc_r + {{(CNTR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc          = pc_r;
  assign pc_in_range = (32'(pc_r) < DEPTH_U);
  assign target_oor  = (32'(target) >= DEPTH_U);

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction fetch sequencer: owns the pc, registers the ROM word into the
// holding register and offers it to decode over valid/ready.
module rom_fetch_ctrl
  import rom_fetch_ctrl_pkg::*;
#(
  parameter int CNTR_WIDTH    = CNTR_WIDTH_DEF,
  parameter int ROM_DEPTH     = ROM_DEPTH_DEF,
  parameter int ADDR_WIDTH    = 0,
  parameter int UNDEFINED     = 0,
  parameter int DATA_WIDTH    = 0,
  parameter int COMBINED_DATA = word_width(ADDR_WIDTH, UNDEFINED, DATA_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     step_mode,
  input  logic                     step,
  output logic [CNTR_WIDTH-1:0]    rom_addr,
  input  logic [COMBINED_DATA-1:0] rom_data,
  output logic                     busy,
  output logic                     halted,
  output logic                     fault,
  rom_fetch_ctrl_if.master         dec
);
  fetch_state_e             state_r;
  fetch_state_e             state_nx_s;
  logic [COMBINED_DATA-1:0] instr_r;
  logic                     instr_valid_r;
  logic                     busy_r;
  logic                     halted_r;
  logic                     fault_r;

  logic                     accept_s;
  logic                     jump_acc_s;
  logic                     load_s;
  logic                     pc_clr_s;
  logic                     pc_tgt_s;
  logic                     fault_set_s;
  logic [CNTR_WIDTH-1:0]    pc_s;
  logic                     pc_in_range_s;
  logic                     target_oor_s;

  rom_fetch_ctrl_fetch_pc #(
    .CNTR_WIDTH (CNTR_WIDTH),
    .ROM_DEPTH  (ROM_DEPTH)
  ) u_fetch_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (pc_clr_s),
    .inc         (load_s),
    .load        (pc_tgt_s),
    .target      (dec.jump_target),
    .pc          (pc_s),
    .pc_in_range (pc_in_range_s),
    .target_oor  (target_oor_s)
  );

  // Output decode: fetch/jump/clear controls derived from state and handshake
  always_comb begin
    accept_s    = instr_valid_r && dec.instr_ready;
    jump_acc_s  = accept_s && dec.jump_en;
    load_s      = 1'b0;
    pc_clr_s    = 1'b0;
    pc_tgt_s    = 1'b0;
    fault_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        pc_clr_s = 1'b0;
      end
      ST_RUN: begin
        // a step arriving while the holding register is still full is simply lost
        load_s      = (!instr_valid_r || accept_s) && (!step_mode || step) &&
                      pc_in_range_s && !jump_acc_s;
        pc_tgt_s    = jump_acc_s && !target_oor_s;
        fault_set_s = jump_acc_s && target_oor_s;
      end
      ST_HALT: begin
        pc_clr_s = start;
      end
      default: begin
        pc_clr_s = 1'b0;
      end
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nx_s = ST_RUN;
        else       state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        if (jump_acc_s && target_oor_s) begin
          state_nx_s = ST_HALT;
        end else if (!jump_acc_s && !pc_in_range_s && (!instr_valid_r || accept_s)) begin
          state_nx_s = ST_HALT;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_HALT: begin
        if (start) state_nx_s = ST_RUN;
        else       state_nx_s = ST_HALT;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register with registered status decodes of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
      fault_r  <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      busy_r   <= (state_nx_s == ST_RUN);
      halted_r <= (state_nx_s == ST_HALT);
      if (fault_set_s)   fault_r <= 1'b1;
      else if (pc_clr_s) fault_r <= 1'b0;
      else               fault_r <= fault_r;
    end
  end

  // Instruction holding register and its valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r       <= {COMBINED_DATA{1'b0}};
      instr_valid_r <= 1'b0;
    end else if (load_s) begin
      instr_r       <= rom_data;
      instr_valid_r <= 1'b1;
    end else if (accept_s) begin
      instr_r       <= instr_r;
      instr_valid_r <= 1'b0;
    end else begin
      instr_r       <= instr_r;
      instr_valid_r <= instr_valid_r;
    end
  end

  assign rom_addr        = pc_s;
  assign dec.instr       = instr_r;
  assign dec.instr_valid = instr_valid_r;
  assign busy            = busy_r;
  assign halted          = halted_r;
  assign fault           = fault_r;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed bench for rom_fetch_ctrl: sequential run, stall, jumps, fault,
// async reset and single-step, all against hand-computed values.
module tb_rom_fetch_ctrl;
  import rom_fetch_ctrl_pkg::*;

  localparam int CW = 5;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          step_mode;
  logic          step;
  logic [CW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          busy;
  logic          halted;
  logic          fault;
  logic [DW-1:0] rom_mem [32];

  int checks = 0;
  int errors = 0;
  int nacc;

  rom_fetch_ctrl_if #(.CNTR_WIDTH(CW), .COMBINED_DATA(DW)) dec_if ();

  rom_fetch_ctrl #(
    .CNTR_WIDTH (CW),
    .ROM_DEPTH  (24),
    .ADDR_WIDTH (0),
    .UNDEFINED  (0),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault),
    .dec       (dec_if)
  );

  assign rom_data = rom_mem[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input int w, input int addr);
    check({tag, "_valid"}, 32'(dec_if.instr_valid), 32'd1);
    check({tag, "_instr"}, 32'(dec_if.instr), 32'(w));
    check({tag, "_addr"}, 32'(rom_addr), 32'(addr));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_instr"}, 32'(dec_if.instr), 32'd0);
    check({tag, "_valid"}, 32'(dec_if.instr_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom_mem[i] = (i < 24) ? 8'(i) : 8'hEE;
    rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
    dec_if.instr_ready = 1'b0; dec_if.jump_en = 1'b0; dec_if.jump_target = 5'd0;

    // reset values
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    dec_if.instr_ready = 1'b1;

    // full program, one word per cycle, then end-of-program halt
    @(negedge clk);
    start = 1'b0;
    check("run_busy", 32'(busy), 32'd1);
    check("run_first_valid", 32'(dec_if.instr_valid), 32'd0);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      check_word("seq", i, i + 1);
    end
    @(negedge clk);
    check("eop_halted", 32'(halted), 32'd1);
    check("eop_busy", 32'(busy), 32'd0);
    check("eop_fault", 32'(fault), 32'd0);
    check("eop_valid", 32'(dec_if.instr_valid), 32'd0);
    check("eop_addr", 32'(rom_addr), 32'd24);

    // restart from HALT
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_valid", 32'(dec_if.instr_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_word("pre_jump", i, i + 1);
    end

    // accept word 5 with an in-range jump to 2
    dec_if.jump_en = 1'b1;
    dec_if.jump_target = 5'd2;
    @(negedge clk);
    dec_if.jump_en = 1'b0;
    check("jump_bubble_valid", 32'(dec_if.instr_valid), 32'd0);
    check("jump_bubble_addr", 32'(rom_addr), 32'd2);
    for (int i = 2; i < 5; i++) begin
      @(negedge clk);
      check_word("post_jump", i, i + 1);
    end

    // decode stalls three cycles on word 4
    dec_if.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_word("stall", 4, 5);
    end
    dec_if.instr_ready = 1'b1;
    @(negedge clk);
    check_word("after_stall", 5, 6);
    @(negedge clk);
    check_word("after_stall", 6, 7);

    // out-of-range jump faults and halts
    dec_if.jump_en = 1'b1;
    dec_if.jump_target = 5'd30;
    @(negedge clk);
    dec_if.jump_en = 1'b0;
    check("oor_halted", 32'(halted), 32'd1);
    check("oor_fault", 32'(fault), 32'd1);
    check("oor_busy", 32'(busy), 32'd0);
    check("oor_valid", 32'(dec_if.instr_valid), 32'd0);
    check("oor_addr_hold", 32'(rom_addr), 32'd7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("clr_fault", 32'(fault), 32'd0);
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_halted", 32'(halted), 32'd0);
    @(negedge clk);
    check_word("refetch", 0, 1);

    // asynchronous reset while an instruction is pending
    #1 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    step_mode = 1'b1;
    step = 1'b0;
    dec_if.instr_ready = 1'b1;

    // single-step: pulses at cycles 3, 10, 11 yield exactly words 0, 1, 2
    nacc = 0;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (dec_if.instr_valid) begin
        check("step_word", 32'(dec_if.instr), 32'(nacc));
        nacc++;
      end
      step = (c == 3 || c == 10 || c == 11);
    end
    check("step_count", 32'(nacc), 32'd3);
    check("step_addr", 32'(rom_addr), 32'd3);

    // a step while the held word is not accepted is dropped
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    check_word("step_load", 3, 4);
    dec_if.instr_ready = 1'b0;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check_word("step_blocked", 3, 4);
    @(negedge clk);
    dec_if.instr_ready = 1'b1;
    @(negedge clk);
    check("drop_valid", 32'(dec_if.instr_valid), 32'd0);
    check("drop_addr", 32'(rom_addr), 32'd4);
    @(negedge clk);
    check("drop_valid_hold", 32'(dec_if.instr_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
